// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter: FSM states, grant bit positions
// and default bus widths.
package mem_arbiter_pkg;

   localparam int DEF_WIDTH     = 128;
   localparam int DEF_ADDR_SIZE = 32;

   // Bit positions inside a one-hot grant / request vector
   localparam int GNT_IC = 0;
   localparam int GNT_DR = 1;
   localparam int GNT_DW = 2;

   typedef logic [2:0] grant_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache request/ack paths and the synchronous memory port.
// The master modport is the arbiter's view; slave is the caches plus memory.
interface mem_arbiter_if #(
   parameter int WIDTH     = 128,
   parameter int ADDR_SIZE = 32
);
   logic                 ic_read_req;
   logic [ADDR_SIZE-1:0] ic_read_addr;
   logic                 ic_read_ack;
   logic [WIDTH-1:0]     ic_read_data;

   logic                 dc_read_req;
   logic [ADDR_SIZE-1:0] dc_read_addr;
   logic                 dc_read_ack;
   logic [WIDTH-1:0]     dc_read_data;

   logic                 dc_write_req;
   logic [ADDR_SIZE-1:0] dc_write_addr;
   logic [WIDTH-1:0]     dc_write_data;
   logic                 dc_write_ack;

   logic                 mem_enable;
   logic                 mem_rw;
   logic                 mem_ack;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic [WIDTH-1:0]     mem_data_in;
   logic [WIDTH-1:0]     mem_data_out;

   modport master (
      input  ic_read_req, ic_read_addr,
      input  dc_read_req, dc_read_addr,
      input  dc_write_req, dc_write_addr, dc_write_data,
      input  mem_ack, mem_data_in,
      output ic_read_ack, ic_read_data,
      output dc_read_ack, dc_read_data,
      output dc_write_ack,
      output mem_enable, mem_rw, mem_addr, mem_data_out
   );

   modport slave (
      output ic_read_req, ic_read_addr,
      output dc_read_req, dc_read_addr,
      output dc_write_req, dc_write_addr, dc_write_data,
      output mem_ack, mem_data_in,
      input  ic_read_ack, ic_read_data,
      input  dc_read_ack, dc_read_data,
      input  dc_write_ack,
      input  mem_enable, mem_rw, mem_addr, mem_data_out
   );

endinterface

// File: rtl/mem_arbiter_select.sv
// Fixed-priority grant picker: write-back, then data read, then instruction
// read, except that a starved instruction read jumps the queue.
module mem_arb_select
   import mem_arbiter_pkg::*;
(
   input  grant_t req,
   input  logic   starve,
   output grant_t grant
);

   always_comb begin
      grant = '0;
      if (starve && req[GNT_IC]) begin
         grant[GNT_IC] = 1'b1;
      end else if (req[GNT_DW]) begin
         grant[GNT_DW] = 1'b1;
      end else if (req[GNT_DR]) begin
         grant[GNT_DR] = 1'b1;
      end else if (req[GNT_IC]) begin
         grant[GNT_IC] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one transaction at a time, IDLE -> BUSY -> RESP,
// with a starvation guard so data-side traffic cannot lock out the icache.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
   parameter int STARVE_LIMIT = 4
) (
   input logic           clk,
   input logic           reset,
   mem_arbiter_if.master bus
);

   arb_state_t           state;
   grant_t               req_vec;
   grant_t               grant_next;
   grant_t               grant_q;
   logic [3:0]           starve_cnt;
   logic                 starve;
   logic [ADDR_SIZE-1:0] sel_addr;

   logic                 mem_enable_q;
   logic                 mem_rw_q;
   logic [ADDR_SIZE-1:0] mem_addr_q;
   logic [WIDTH-1:0]     mem_wdata_q;
   logic [WIDTH-1:0]     ic_data_q;
   logic [WIDTH-1:0]     dc_data_q;
   logic                 ic_ack_q;
   logic                 dr_ack_q;
   logic                 dw_ack_q;

   assign starve = (starve_cnt == 4'(STARVE_LIMIT));

   always_comb begin
      req_vec         = '0;
      req_vec[GNT_IC] = bus.ic_read_req;
      req_vec[GNT_DR] = bus.dc_read_req;
      req_vec[GNT_DW] = bus.dc_write_req;
   end

   mem_arb_select u_select (
      .req    (req_vec),
      .starve (starve),
      .grant  (grant_next)
   );

   // Only the winner's address is looked at; losers' buses are don't-care.
   always_comb begin
      sel_addr = bus.ic_read_addr;
      if (grant_next[GNT_DW]) begin
         sel_addr = bus.dc_write_addr;
      end else if (grant_next[GNT_DR]) begin
         sel_addr = bus.dc_read_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         grant_q      <= '0;
         starve_cnt   <= '0;
         mem_enable_q <= 1'b0;
         mem_rw_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         ic_data_q    <= '0;
         dc_data_q    <= '0;
         ic_ack_q     <= 1'b0;
         dr_ack_q     <= 1'b0;
         dw_ack_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant_next) begin
                  grant_q      <= grant_next;
                  mem_addr_q   <= sel_addr;
                  mem_rw_q     <= grant_next[GNT_DW];
                  mem_enable_q <= 1'b1;
                  if (grant_next[GNT_DW]) begin
                     mem_wdata_q <= bus.dc_write_data;
                  end
                  if (grant_next[GNT_IC] || !bus.ic_read_req) begin
                     starve_cnt <= '0;
                  end else if (!starve) begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
                  state <= BUSY;
               end else begin
                  mem_enable_q <= 1'b0;
                  if (!bus.ic_read_req) begin
                     starve_cnt <= '0;
                  end
               end
            end
            BUSY: begin
               if (bus.mem_ack) begin
                  if (!mem_rw_q && grant_q[GNT_IC]) begin
                     ic_data_q <= bus.mem_data_in;
                  end
                  if (!mem_rw_q && grant_q[GNT_DR]) begin
                     dc_data_q <= bus.mem_data_in;
                  end
                  ic_ack_q     <= grant_q[GNT_IC];
                  dr_ack_q     <= grant_q[GNT_DR];
                  dw_ack_q     <= grant_q[GNT_DW];
                  mem_enable_q <= 1'b0;
                  state        <= RESP;
               end
            end
            RESP: begin
               ic_ack_q <= 1'b0;
               dr_ack_q <= 1'b0;
               dw_ack_q <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_enable   = mem_enable_q;
   assign bus.mem_rw       = mem_rw_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_data_out = mem_wdata_q;
   assign bus.ic_read_ack  = ic_ack_q;
   assign bus.ic_read_data = ic_data_q;
   assign bus.dc_read_ack  = dr_ack_q;
   assign bus.dc_read_data = dc_data_q;
   assign bus.dc_write_ack = dw_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: priority table, directed corner sequences and a
// randomized run against a transaction-level arbitration/memory model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int WIDTH        = 128;
   localparam int ADDR_SIZE    = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int RAND_CYCLES  = 3000;

   localparam logic [ADDR_SIZE-1:0] IC_A = 32'h0000_1000;
   localparam logic [ADDR_SIZE-1:0] DR_A = 32'h0000_2000;
   localparam logic [ADDR_SIZE-1:0] DW_A = 32'h0000_3000;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.WIDTH(WIDTH), .ADDR_SIZE(ADDR_SIZE)) bus ();

   mem_arbiter #(
      .WIDTH        (WIDTH),
      .ADDR_SIZE    (ADDR_SIZE),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic                 ic;
      logic                 dr;
      logic                 dw;
      logic [ADDR_SIZE-1:0] exp_addr;
      logic                 exp_rw;
      logic [2:0]           exp_ack;
   } vec_t;

   vec_t vecs [7];

   int total = 0;
   int bad   = 0;

   bit                   ok;
   logic [2:0]           acks;
   logic [WIDTH-1:0]     line_a;
   logic [WIDTH-1:0]     line_b;
   logic [WIDTH-1:0]     held_ic;
   logic [WIDTH-1:0]     held_dc;
   int                   n_dc;
   bit                   got_ic;
   bit                   is_ic;

   // reference model state for the randomized run
   logic [WIDTH-1:0]     mem_model [logic [ADDR_SIZE-1:0]];
   int                   ph;
   int                   ph_n;
   int                   win;
   int                   starve;
   int                   lat;
   logic                 rq [3];
   logic [ADDR_SIZE-1:0] ra [3];
   logic [WIDTH-1:0]     wdat;
   logic                 ack_drv;
   logic [ADDR_SIZE-1:0] txn_addr;
   logic                 txn_rw;
   logic [WIDTH-1:0]     txn_wdata;
   logic [WIDTH-1:0]     exp_ic_data;
   logic [WIDTH-1:0]     exp_dc_data;
   logic [2:0]           exp_ack;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] got,
                              input logic [WIDTH-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic ic, input logic dr, input logic dw,
                                input logic [ADDR_SIZE-1:0] ic_a,
                                input logic [ADDR_SIZE-1:0] dr_a,
                                input logic [ADDR_SIZE-1:0] dw_a,
                                input logic [WIDTH-1:0] wd);
      bus.ic_read_req   = ic;
      bus.dc_read_req   = dr;
      bus.dc_write_req  = dw;
      bus.ic_read_addr  = ic_a;
      bus.dc_read_addr  = dr_a;
      bus.dc_write_addr = dw_a;
      bus.dc_write_data = wd;
   endtask

   task automatic idle_inputs();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      bus.mem_ack     = 1'b0;
      bus.mem_data_in = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   function automatic logic [2:0] get_acks();
      return {bus.dc_write_ack, bus.dc_read_ack, bus.ic_read_ack};
   endfunction

   function automatic logic [WIDTH-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [WIDTH-1:0] mem_read(input logic [ADDR_SIZE-1:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return {4{a ^ 32'hA5A5_0000}};
   endfunction

   // Called in the first BUSY cycle; leaves the bench in the ack cycle.
   task automatic serve(input int wait_cycles, input logic [WIDTH-1:0] rdata,
                        output logic [2:0] seen);
      bus.mem_data_in = rdata;
      for (int i = 0; i < wait_cycles; i++) begin
         tick();
         checkOutput("busy_enable_held", WIDTH'(bus.mem_enable), WIDTH'(1));
         checkOutput("busy_no_ack", WIDTH'(get_acks()), '0);
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      seen = get_acks();
   endtask

   task automatic wait_grant(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (bus.mem_enable === 1'b1) found = 1'b1;
      end
      checkOutput("grant_within_bound", WIDTH'(found), WIDTH'(1));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, IC_A, 1'b0, 3'b001};
      vecs[1] = '{1'b0, 1'b1, 1'b0, DR_A, 1'b0, 3'b010};
      vecs[2] = '{1'b1, 1'b1, 1'b0, DR_A, 1'b0, 3'b010};
      vecs[3] = '{1'b0, 1'b0, 1'b1, DW_A, 1'b1, 3'b100};
      vecs[4] = '{1'b1, 1'b0, 1'b1, DW_A, 1'b1, 3'b100};
      vecs[5] = '{1'b0, 1'b1, 1'b1, DW_A, 1'b1, 3'b100};
      vecs[6] = '{1'b1, 1'b1, 1'b1, DW_A, 1'b1, 3'b100};

      // reset held with every request raised
      idle_inputs();
      line_a = rand_line();
      applyStimulus(1'b1, 1'b1, 1'b1, IC_A, DR_A, DW_A, line_a);
      reset = 1'b0;
      tick();
      tick();
      checkOutput("rst_mem_enable", WIDTH'(bus.mem_enable), '0);
      checkOutput("rst_mem_rw", WIDTH'(bus.mem_rw), '0);
      checkOutput("rst_mem_addr", WIDTH'(bus.mem_addr), '0);
      checkOutput("rst_mem_data_out", bus.mem_data_out, '0);
      checkOutput("rst_acks", WIDTH'(get_acks()), '0);
      checkOutput("rst_ic_data", bus.ic_read_data, '0);
      checkOutput("rst_dc_data", bus.dc_read_data, '0);
      reset = 1'b1;
      tick();
      checkOutput("post_rst_enable", WIDTH'(bus.mem_enable), WIDTH'(1));
      checkOutput("post_rst_rw", WIDTH'(bus.mem_rw), WIDTH'(1));
      checkOutput("post_rst_addr", WIDTH'(bus.mem_addr), WIDTH'(DW_A));
      checkOutput("post_rst_wdata", bus.mem_data_out, line_a);
      serve(0, '0, acks);
      checkOutput("post_rst_ack", WIDTH'(acks), WIDTH'(3'b100));
      idle_inputs();
      tick();

      // priority table, each vector from a freshly reset arbiter
      for (int v = 0; v < 7; v++) begin
         idle_inputs();
         do_reset();
         line_b = rand_line();
         applyStimulus(vecs[v].ic, vecs[v].dr, vecs[v].dw, IC_A, DR_A, DW_A, line_b);
         tick();
         checkOutput("vec_enable", WIDTH'(bus.mem_enable), WIDTH'(1));
         checkOutput("vec_addr", WIDTH'(bus.mem_addr), WIDTH'(vecs[v].exp_addr));
         checkOutput("vec_rw", WIDTH'(bus.mem_rw), WIDTH'(vecs[v].exp_rw));
         serve(1, rand_line(), acks);
         checkOutput("vec_ack", WIDTH'(acks), WIDTH'(vecs[v].exp_ack));
         idle_inputs();
         tick();
         checkOutput("vec_ack_one_cycle", WIDTH'(get_acks()), '0);
      end

      // single icache line read
      idle_inputs();
      do_reset();
      line_a = {32'hDEADBEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0040, '0, '0, '0);
      tick();
      checkOutput("ic_enable", WIDTH'(bus.mem_enable), WIDTH'(1));
      checkOutput("ic_rw", WIDTH'(bus.mem_rw), '0);
      checkOutput("ic_addr", WIDTH'(bus.mem_addr), WIDTH'(32'h40));
      serve(2, line_a, acks);
      checkOutput("ic_ack", WIDTH'(acks), WIDTH'(3'b001));
      checkOutput("ic_data", bus.ic_read_data, line_a);
      bus.ic_read_req = 1'b0;
      bus.mem_data_in = '0;
      tick();
      checkOutput("ic_ack_drop", WIDTH'(bus.ic_read_ack), '0);
      checkOutput("ic_data_held", bus.ic_read_data, line_a);

      // write-back and refill of the same line in the same cycle
      line_b = rand_line();
      applyStimulus(1'b0, 1'b1, 1'b1, '0, 32'h100, 32'h100, line_b);
      tick();
      checkOutput("wb_rw", WIDTH'(bus.mem_rw), WIDTH'(1));
      checkOutput("wb_addr", WIDTH'(bus.mem_addr), WIDTH'(32'h100));
      checkOutput("wb_wdata", bus.mem_data_out, line_b);
      serve(1, '0, acks);
      checkOutput("wb_ack", WIDTH'(acks), WIDTH'(3'b100));
      bus.dc_write_req = 1'b0;
      tick();
      checkOutput("wb_gap_idle", WIDTH'(bus.mem_enable), '0);
      tick();
      checkOutput("rf_enable", WIDTH'(bus.mem_enable), WIDTH'(1));
      checkOutput("rf_rw", WIDTH'(bus.mem_rw), '0);
      checkOutput("rf_addr", WIDTH'(bus.mem_addr), WIDTH'(32'h100));
      serve(1, line_b, acks);
      checkOutput("rf_ack", WIDTH'(acks), WIDTH'(3'b010));
      checkOutput("rf_data", bus.dc_read_data, line_b);
      idle_inputs();
      tick();

      // starvation: dc_read held continuously against a waiting icache read
      do_reset();
      applyStimulus(1'b1, 1'b1, 1'b0, IC_A, DR_A, '0, '0);
      for (int round = 0; round < 2; round++) begin
         n_dc   = 0;
         got_ic = 1'b0;
         for (int g = 0; g < 8 && !got_ic; g++) begin
            wait_grant(ok);
            if (!ok) break;
            is_ic = (bus.mem_addr == IC_A);
            serve(0, rand_line(), acks);
            if (is_ic) got_ic = 1'b1;
            else n_dc++;
         end
         checkOutput("starve_dc_grants", WIDTH'(n_dc), WIDTH'(STARVE_LIMIT));
         checkOutput("starve_ic_granted", WIDTH'(got_ic), WIDTH'(1));
      end
      idle_inputs();
      tick();

      // reset while BUSY, followed by a late memory ack
      applyStimulus(1'b0, 1'b1, 1'b0, '0, DR_A, '0, '0);
      tick();
      checkOutput("rbusy_enable", WIDTH'(bus.mem_enable), WIDTH'(1));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checkOutput("rbusy_enable_dropped", WIDTH'(bus.mem_enable), '0);
      checkOutput("rbusy_no_ack", WIDTH'(get_acks()), '0);
      idle_inputs();
      bus.mem_ack     = 1'b1;
      bus.mem_data_in = rand_line();
      tick();
      bus.mem_ack = 1'b0;
      checkOutput("late_ack_no_ack", WIDTH'(get_acks()), '0);
      checkOutput("late_ack_no_enable", WIDTH'(bus.mem_enable), '0);
      tick();
      checkOutput("late_ack_still_quiet", WIDTH'(get_acks()), '0);
      checkOutput("late_ack_dc_data", bus.dc_read_data, '0);

      // requester drops its req mid-transaction, then a stray ack in IDLE
      line_a = rand_line();
      applyStimulus(1'b0, 1'b1, 1'b0, '0, DR_A, '0, '0);
      tick();
      bus.dc_read_req = 1'b0;
      serve(1, line_a, acks);
      checkOutput("drop_ack", WIDTH'(acks), WIDTH'(3'b010));
      checkOutput("drop_data", bus.dc_read_data, line_a);
      tick();
      checkOutput("drop_ack_once", WIDTH'(get_acks()), '0);
      held_ic = bus.ic_read_data;
      held_dc = bus.dc_read_data;
      bus.mem_ack     = 1'b1;
      bus.mem_data_in = rand_line();
      tick();
      bus.mem_ack = 1'b0;
      checkOutput("stray_enable", WIDTH'(bus.mem_enable), '0);
      checkOutput("stray_acks", WIDTH'(get_acks()), '0);
      checkOutput("stray_ic_data", bus.ic_read_data, held_ic);
      checkOutput("stray_dc_data", bus.dc_read_data, held_dc);

      // randomized traffic against the reference model
      idle_inputs();
      do_reset();
      ph          = 0;
      win         = 0;
      starve      = 0;
      lat         = 0;
      ack_drv     = 1'b0;
      wdat        = '0;
      exp_ic_data = '0;
      exp_dc_data = '0;
      txn_addr    = '0;
      txn_rw      = 1'b0;
      txn_wdata   = '0;
      for (int i = 0; i < 3; i++) begin
         rq[i] = 1'b0;
         ra[i] = '0;
      end
      for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
         tick();
         exp_ack = '0;
         ph_n    = ph;
         if (ph == 0) begin
            if (rq[0] || rq[1] || rq[2]) begin
               if (rq[0] && starve == STARVE_LIMIT) win = 0;
               else if (rq[2]) win = 2;
               else if (rq[1]) win = 1;
               else win = 0;
               if (win == 0 || !rq[0]) starve = 0;
               else if (starve < STARVE_LIMIT) starve = starve + 1;
               txn_addr  = ra[win];
               txn_rw    = (win == 2);
               txn_wdata = wdat;
               lat       = $urandom_range(0, 3);
               ph_n      = 1;
            end else if (!rq[0]) begin
               starve = 0;
            end
         end else if (ph == 1) begin
            if (ack_drv) begin
               exp_ack[win] = 1'b1;
               if (txn_rw) mem_model[txn_addr] = txn_wdata;
               else if (win == 0) exp_ic_data = mem_read(txn_addr);
               else exp_dc_data = mem_read(txn_addr);
               ph_n = 2;
            end
         end else begin
            ph_n = 0;
         end
         ph = ph_n;

         checkOutput("rnd_enable", WIDTH'(bus.mem_enable), WIDTH'(ph == 1));
         checkOutput("rnd_acks", WIDTH'(get_acks()), WIDTH'(exp_ack));
         checkOutput("rnd_ic_data", bus.ic_read_data, exp_ic_data);
         checkOutput("rnd_dc_data", bus.dc_read_data, exp_dc_data);
         if (ph == 1) begin
            checkOutput("rnd_addr", WIDTH'(bus.mem_addr), WIDTH'(txn_addr));
            checkOutput("rnd_rw", WIDTH'(bus.mem_rw), WIDTH'(txn_rw));
            if (txn_rw) checkOutput("rnd_wdata", bus.mem_data_out, txn_wdata);
         end

         if (ph == 2) rq[win] = 1'b0;
         for (int k = 0; k < 3; k++) begin
            if (!rq[k] && !(ph == 2 && win == k) && $urandom_range(0, 2) == 0) begin
               rq[k] = 1'b1;
               ra[k] = 32'h100 + 32'($urandom_range(0, 3)) * 32'h40;
               if (k == 2) wdat = rand_line();
            end
         end
         applyStimulus(rq[0], rq[1], rq[2], ra[0], ra[1], ra[2], wdat);
         if (ph == 1) begin
            ack_drv         = (lat == 0);
            if (lat > 0) lat = lat - 1;
            bus.mem_data_in = mem_read(txn_addr);
         end else begin
            ack_drv         = ($urandom_range(0, 7) == 0);
            bus.mem_data_in = rand_line();
         end
         bus.mem_ack = ack_drv;
      end

      idle_inputs();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
